// File: rtl/hermes_tx_framer.sv
// hermes_tx_framer
// Registered output stage between the DMNI Hermes transmit port and the
// router local input port. Flits pass through a 2-entry skid FIFO. A framing
// FSM follows each packet (header, size, payload) on the output side. After
// every packet it inserts a programmable idle gap. It also keeps packet and
// flit statistics.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   rx_i, data_i      upstream flit valid / data
//   credit_o          upstream credit (FIFO not full, low during reset)
//   tx_o, data_o      downstream flit valid / data (FIFO head)
//   credit_i          downstream credit
//   gap_i             idle cycles enforced after each packet (0 = none)
//   clear_i           zeroes both statistics counters (wins over increments)
//   pkt_active_o      packet in flight on the output side
//   pkt_count_o       packets fully sent downstream
//   flit_count_o      flits sent downstream
//
// State   | Meaning
// HEADER  | waiting for / sending the header flit
// SIZE    | sending the payload-size flit
// PAYLOAD | sending payload flits, remaining counts down
// GAP     | enforced idle after a packet, output held off
module hermes_tx_framer #(
  parameter int HERMES_FLIT_SIZE = 32,
  parameter int GAP_WIDTH        = 8,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        rx_i,
  output logic                        credit_o,
  input  logic [HERMES_FLIT_SIZE-1:0] data_i,
  output logic                        tx_o,
  input  logic                        credit_i,
  output logic [HERMES_FLIT_SIZE-1:0] data_o,
  input  logic [GAP_WIDTH-1:0]        gap_i,
  input  logic                        clear_i,
  output logic                        pkt_active_o,
  output logic [CNT_WIDTH-1:0]        pkt_count_o,
  output logic [CNT_WIDTH-1:0]        flit_count_o
);

  typedef enum logic [1:0] {
    S_HEADER  = 2'd0,
    S_SIZE    = 2'd1,
    S_PAYLOAD = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  localparam logic [HERMES_FLIT_SIZE-1:0] ONE_R = 1;
  localparam logic [GAP_WIDTH-1:0]        ONE_G = 1;
  localparam logic [CNT_WIDTH-1:0]        ONE_C = 1;

  state_t                      state, state_nxt;
  logic [HERMES_FLIT_SIZE-1:0] mem [2];
  logic                        wr_ptr, rd_ptr;
  logic [1:0]                  count;
  logic                        push, pop, eop;
  logic [HERMES_FLIT_SIZE-1:0] remaining, remaining_nxt;
  logic [GAP_WIDTH-1:0]        gap_cnt, gap_cnt_nxt;

  // Credit is derived from registered occupancy only. A pop therefore frees
  // a slot for the upstream side one cycle later.
  assign credit_o = !rst_i && (count != 2'd2);
  assign tx_o     = (count != 2'd0) && (state != S_GAP);
  assign data_o   = mem[rd_ptr];
  assign push     = rx_i && credit_o;
  assign pop      = tx_o && credit_i;

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    gap_cnt_nxt   = gap_cnt;
    eop           = 1'b0;
    case (state)
      S_HEADER: begin
        if (pop) state_nxt = S_SIZE;
      end
      S_SIZE: begin
        if (pop) begin
          remaining_nxt = data_o;
          if (data_o == '0) eop = 1'b1;
          else              state_nxt = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (pop) begin
          if (remaining == ONE_R) eop = 1'b1;
          if (remaining != '0)    remaining_nxt = remaining - ONE_R;
        end
      end
      S_GAP: begin
        if (gap_cnt != '0) gap_cnt_nxt = gap_cnt - ONE_G;
        // Leaving on zero as well keeps a corrupted counter from locking the port.
        if (gap_cnt <= ONE_G) state_nxt = S_HEADER;
      end
      default: state_nxt = S_HEADER;
    endcase
    if (eop) begin
      if (gap_i == '0) begin
        state_nxt = S_HEADER;
      end else begin
        state_nxt   = S_GAP;
        gap_cnt_nxt = gap_i;
      end
    end
  end

  assign pkt_active_o = (state == S_SIZE) || (state == S_PAYLOAD) ||
                        ((state == S_HEADER) && pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_HEADER;
      remaining <= '0;
      gap_cnt   <= '0;
      mem[0]    <= '0;
      mem[1]    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      gap_cnt   <= gap_cnt_nxt;
      if (push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      pkt_count_o  <= '0;
      flit_count_o <= '0;
    end else begin
      if (eop) pkt_count_o  <= pkt_count_o + ONE_C;
      if (pop) flit_count_o <= flit_count_o + ONE_C;
    end
  end

endmodule
